// File: rtl/stddev_stream_nd.sv
// Streaming per-dimension standard deviation about a caller-supplied center.
// Points stream in on a valid/ready beat interface. Each run accumulates the sum of
// squared deviations for every dimension. The unit then works through the dimensions
// one at a time, using a sequential restoring divide (sum / count) followed by a
// sequential bit-pair square root. All results are published together with a
// one-cycle done pulse.
module stddev_stream_nd #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_DIMS   = 2,
  parameter int unsigned MAX_POINTS = 64,
  localparam int unsigned CNT_W     = $clog2(MAX_POINTS + 1),
  localparam int unsigned ACC_W     = 2 * DATA_WIDTH + CNT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_DIMS*DATA_WIDTH-1:0] center,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [NUM_DIMS*DATA_WIDTH-1:0] s_data,
  input  logic                           s_last,
  output logic                           busy,
  output logic                           done,
  output logic [CNT_W-1:0]               count_out,
  output logic [NUM_DIMS*DATA_WIDTH-1:0] stddev
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned STEP_W = $clog2(ACC_W);
  localparam int unsigned DIM_W  = (NUM_DIMS > 1) ? $clog2(NUM_DIMS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StDivide,
    StSqrt,
    StDone
  } state_e;

  state_e                      state_q, state_d;
  logic [NUM_DIMS*DW-1:0]      center_q, center_d;
  logic [ACC_W-1:0]            acc_q [NUM_DIMS];
  logic [ACC_W-1:0]            acc_d [NUM_DIMS];
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [STEP_W-1:0]           step_q, step_d;
  logic [DIM_W-1:0]            dim_q, dim_d;
  // Division state: partial remainder and quotient shift register.
  logic [CNT_W-1:0]            rem_q, rem_d;
  logic [2*DW-1:0]             quot_q, quot_d;
  // Square-root state: partial remainder and partial root.
  logic [DW+1:0]               srem_q, srem_d;
  logic [DW-1:0]               root_q, root_d;
  logic [DW-1:0]               res_q [NUM_DIMS];
  logic [DW-1:0]               res_d [NUM_DIMS];
  logic [NUM_DIMS*DW-1:0]      stddev_q, stddev_d;
  logic [CNT_W-1:0]            count_q, count_d;

  // Per-dimension deviation terms.
  logic signed [DW:0]          diff [NUM_DIMS];
  logic [DW:0]                 mag  [NUM_DIMS];
  logic [ACC_W-1:0]            sq   [NUM_DIMS];

  // Divide/sqrt single-step datapath.
  logic [ACC_W-1:0]            acc_sel;
  logic [CNT_W:0]              rsh;
  logic                        q_bit;
  logic [CNT_W-1:0]            rem_sub;
  logic [DW+3:0]               ssh;
  logic [DW+1:0]               trial;
  logic                        s_bit;
  logic [DW+1:0]               srem_sub;
  logic [DW-1:0]               root_next;

  // Squared deviation of each incoming coordinate from the latched center.
  always_comb begin
    for (int d = 0; d < NUM_DIMS; d++) begin
      diff[d] = $signed({s_data[d*DW+DW-1], s_data[d*DW +: DW]}) -
                $signed({center_q[d*DW+DW-1], center_q[d*DW +: DW]});
      // Square via magnitude so the product stays unsigned.
      mag[d]  = diff[d][DW] ? -diff[d] : diff[d];
      sq[d]   = ACC_W'(mag[d]) * ACC_W'(mag[d]);
    end
  end

  // One restoring-division step and one bit-pair square-root step.
  always_comb begin
    acc_sel   = acc_q[dim_q];
    // The accumulator of the active dimension is shifted left each step, so its MSB is
    // the next dividend bit.
    rsh       = {rem_q, acc_sel[ACC_W-1]};
    q_bit     = (rsh >= {1'b0, cnt_q});
    rem_sub   = rsh[CNT_W-1:0] - cnt_q;

    // The quotient register is shifted left two bits per step, so its top pair is the
    // next radicand pair.
    ssh       = {srem_q, quot_q[2*DW-1 -: 2]};
    trial     = {root_q, 2'b01};
    s_bit     = (ssh >= {2'b00, trial});
    srem_sub  = ssh[DW+1:0] - trial;
    root_next = {root_q[DW-2:0], s_bit};
  end

  // Next-state and datapath control for the run sequence.
  always_comb begin
    state_d  = state_q;
    center_d = center_q;
    cnt_d    = cnt_q;
    step_d   = step_q;
    dim_d    = dim_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    srem_d   = srem_q;
    root_d   = root_q;
    stddev_d = stddev_q;
    count_d  = count_q;
    for (int d = 0; d < NUM_DIMS; d++) begin
      acc_d[d] = acc_q[d];
      res_d[d] = res_q[d];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StAccum;
          center_d = center;
          cnt_d    = '0;
          for (int d = 0; d < NUM_DIMS; d++) acc_d[d] = '0;
        end
      end

      StAccum: begin
        if (s_valid) begin
          for (int d = 0; d < NUM_DIMS; d++) acc_d[d] = acc_q[d] + sq[d];
          cnt_d = cnt_q + 1'b1;
          if (s_last || (cnt_q == CNT_W'(MAX_POINTS - 1))) begin
            state_d = StDivide;
            step_d  = '0;
            rem_d   = '0;
            dim_d   = '0;
          end
        end
      end

      StDivide: begin
        for (int d = 0; d < NUM_DIMS; d++) begin
          if (DIM_W'(d) == dim_q) acc_d[d] = acc_q[d] << 1;
        end
        // Quotient bits above 2*DW are always zero and simply fall off the top.
        quot_d = {quot_q[2*DW-2:0], q_bit};
        rem_d  = q_bit ? rem_sub : rsh[CNT_W-1:0];
        if (step_q == STEP_W'(ACC_W - 1)) begin
          state_d = StSqrt;
          step_d  = '0;
          srem_d  = '0;
          root_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      StSqrt: begin
        quot_d = {quot_q[2*DW-3:0], 2'b00};
        srem_d = s_bit ? srem_sub : ssh[DW+1:0];
        root_d = root_next;
        if (step_q == STEP_W'(DW - 1)) begin
          for (int d = 0; d < NUM_DIMS; d++) begin
            if (DIM_W'(d) == dim_q) res_d[d] = root_next;
          end
          step_d = '0;
          if (dim_q == DIM_W'(NUM_DIMS - 1)) begin
            state_d = StDone;
            // Publish every dimension at once, including the root finishing this cycle.
            count_d = cnt_q;
            for (int d = 0; d < NUM_DIMS; d++) stddev_d[d*DW +: DW] = res_d[d];
          end else begin
            state_d = StDivide;
            dim_d   = dim_q + 1'b1;
            rem_d   = '0;
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      center_q <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      dim_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      srem_q   <= '0;
      root_q   <= '0;
      stddev_q <= '0;
      count_q  <= '0;
      for (int d = 0; d < NUM_DIMS; d++) begin
        acc_q[d] <= '0;
        res_q[d] <= '0;
      end
    end else begin
      state_q  <= state_d;
      center_q <= center_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      dim_q    <= dim_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      srem_q   <= srem_d;
      root_q   <= root_d;
      stddev_q <= stddev_d;
      count_q  <= count_d;
      for (int d = 0; d < NUM_DIMS; d++) begin
        acc_q[d] <= acc_d[d];
        res_q[d] <= res_d[d];
      end
    end
  end

  // Status outputs decoded from the current state.
  always_comb begin
    s_ready   = (state_q == StAccum);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    count_out = count_q;
    stddev    = stddev_q;
  end

endmodule

// File: tb/tb_stddev_stream_nd.sv
// Self-checking bench for stddev_stream_nd (Q8.8, two dimensions, 64 points).
module tb_stddev_stream_nd;

  localparam int DW   = 16;
  localparam int ND   = 2;
  localparam int MAXP = 64;
  localparam int LAT  = 1 + ND * (2 * DW + 7 + DW);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] center = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        busy;
  logic        done;
  logic [6:0]  count_out;
  logic [31:0] stddev;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] pts[$];

  typedef struct packed {
    logic [31:0]      ctr;
    logic [2:0]       n;
    logic [3:0][31:0] p;
    logic [15:0]      e0;
    logic [15:0]      e1;
    logic [6:0]       ecnt;
  } vec_t;

  vec_t vecs[4];

  stddev_stream_nd #(
    .DATA_WIDTH(DW),
    .NUM_DIMS  (ND),
    .MAX_POINTS(MAXP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .center   (center),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .busy     (busy),
    .done     (done),
    .count_out(count_out),
    .stddev   (stddev)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic longint isqrt(input longint v);
    longint r;
    r = longint'($sqrt(real'(v)));
    while (r * r > v) r--;
    while ((r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  // Reference: floor(sqrt(floor(sum((p-c)^2) / n))) per dimension, over the first n points.
  function automatic void model(input logic [31:0] ctr, input int n,
                                output logic [15:0] e0, output logic [15:0] e1);
    longint sum, dv, r;
    logic [31:0] p;
    e0 = '0;
    e1 = '0;
    for (int d = 0; d < ND; d++) begin
      sum = 0;
      for (int i = 0; i < n; i++) begin
        p   = pts[i];
        dv  = longint'($signed(p[d*16 +: 16])) - longint'($signed(ctr[d*16 +: 16]));
        sum += dv * dv;
      end
      r = isqrt(sum / n);
      if (d == 0) e0 = r[15:0];
      else e1 = r[15:0];
    end
  endfunction

  task automatic set_vec(input int i, input logic [31:0] ctr, input int n,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [15:0] e0, input logic [15:0] e1);
    vecs[i].ctr  = ctr;
    vecs[i].n    = 3'(n);
    vecs[i].p[0] = p0;
    vecs[i].p[1] = p1;
    vecs[i].p[2] = p2;
    vecs[i].p[3] = p3;
    vecs[i].e0   = e0;
    vecs[i].e1   = e1;
    vecs[i].ecnt = 7'(n);
  endtask

  // Starts a run, streams pts, waits for done and checks everything about the run.
  task automatic run(input string tag, input logic [31:0] ctr, input int n_beats,
                     input bit use_last, input bit gaps, input bit poke,
                     input logic [15:0] e0, input logic [15:0] e1, input logic [6:0] ecnt);
    int idx, t_last, guard, wait_cyc;
    bit got;
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b1;
    center = ctr;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    idx    = 0;
    t_last = 0;
    guard  = 0;
    while (guard < 1000) begin
      guard++;
      if (!s_ready || idx >= n_beats) break;
      start  = poke && (guard == 3);
      center = poke ? ~ctr : ctr;
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = pts[idx];
        s_last  = use_last && (idx == n_beats - 1);
        t_last  = cyc;
        idx++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    start   = 1'b0;
    check({tag, "_accepted"}, 64'(idx), 64'(ecnt));
    check({tag, "_ready_low"}, 64'(s_ready), 64'd0);
    got      = 1'b0;
    wait_cyc = 0;
    while (wait_cyc < 400 && !got) begin
      if (done) begin
        got = 1'b1;
      end else begin
        start = poke && (wait_cyc == 5 || wait_cyc == 45 || wait_cyc == 60);
        @(negedge clk);
        wait_cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(cyc - t_last), 64'(LAT));
    check({tag, "_stddev0"}, 64'(stddev[15:0]), 64'(e0));
    check({tag, "_stddev1"}, 64'(stddev[31:16]), 64'(e1));
    check({tag, "_count_out"}, 64'(count_out), 64'(ecnt));
    check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    if (poke) start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    center = ctr;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(stddev), 64'({e1, e0}));
    if (!got) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] e0, e1;
    logic [31:0] ctr;
    int n, seen;

    // {dim1, dim0} packing; Q8.8 values.
    set_vec(0, 32'h0000_0000, 4, 32'h0000_0100, 32'h0000_FF00, 32'h0000_0100, 32'h0000_FF00,
            16'h0100, 16'h0000);
    set_vec(1, 32'h0000_0200, 2, 32'h0000_0000, 32'h0000_0400, 32'h0, 32'h0,
            16'h0200, 16'h0000);
    set_vec(2, 32'h8001_7FFF, 1, 32'h8001_7FFF, 32'h0, 32'h0, 32'h0, 16'h0000, 16'h0000);
    // Largest possible deviation in both directions: |diff| = 0xFFFF.
    set_vec(3, 32'h7FFF_8000, 2, 32'h8000_7FFF, 32'h8000_7FFF, 32'h0, 32'h0,
            16'hFFFF, 16'hFFFF);

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_ready", 64'(s_ready), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_stddev", 64'(stddev), 64'd0);
    check("reset_count", 64'(count_out), 64'd0);

    for (int v = 0; v < 4; v++) begin
      pts.delete();
      for (int i = 0; i < int'(vecs[v].n); i++) pts.push_back(vecs[v].p[i]);
      run($sformatf("vec%0d", v), vecs[v].ctr, int'(vecs[v].n), 1'b1, 1'b0, 1'b0,
          vecs[v].e0, vecs[v].e1, vecs[v].ecnt);
    end

    // Same data with and without idle gaps.
    pts.delete();
    for (int i = 0; i < 10; i++) pts.push_back($urandom);
    ctr = $urandom;
    model(ctr, 10, e0, e1);
    run("nogap", ctr, 10, 1'b1, 1'b0, 1'b0, e0, e1, 7'd10);
    run("gap", ctr, 10, 1'b1, 1'b1, 1'b0, e0, e1, 7'd10);

    // start pulsed while busy and in the done cycle must be ignored.
    pts.delete();
    for (int i = 0; i < 20; i++) pts.push_back($urandom);
    ctr = $urandom;
    model(ctr, 20, e0, e1);
    run("poke", ctr, 20, 1'b1, 1'b1, 1'b1, e0, e1, 7'd20);

    for (int r = 0; r < 5; r++) begin
      pts.delete();
      n = $urandom_range(1, MAXP);
      for (int i = 0; i < n; i++) pts.push_back($urandom);
      ctr = $urandom;
      model(ctr, n, e0, e1);
      run($sformatf("rand%0d", r), ctr, n, 1'b1, r[0], 1'b0, e0, e1, 7'(n));
    end

    // 70 beats, no s_last: capacity limit ends the run after 64.
    pts.delete();
    for (int i = 0; i < 70; i++) pts.push_back($urandom);
    ctr = $urandom;
    model(ctr, MAXP, e0, e1);
    run("cap", ctr, 70, 1'b0, 1'b0, 1'b0, e0, e1, 7'(MAXP));

    // Abort in the middle of the first square root.
    pts.delete();
    pts.push_back(32'h0100_0300);
    pts.push_back(32'hFF00_FD00);
    @(negedge clk);
    start  = 1'b1;
    center = '0;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = pts[0];
    @(negedge clk);
    s_data = pts[1];
    s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(s_ready), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_stddev", 64'(stddev), 64'd0);
    check("abort_count", 64'(count_out), 64'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    // dim0 diffs +-0x300, dim1 diffs +-0x100.
    run("after_abort", 32'h0, 2, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h0100, 7'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stddev_stream_nd.md
STDDEV_STREAM_ND -- requirements
Module: stddev_stream_nd

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one coordinate (signed two's complement, any fixed-point Q format).
REQ-002 SHALL have parameter NUM_DIMS, default 2: number of independent dimensions (channels) per point.
REQ-003 SHALL have parameter MAX_POINTS, default 64: maximum points per run; CNT_W = $clog2(MAX_POINTS+1), ACC_W = 2*DATA_WIDTH+CNT_W.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; latches center.
- center  in  NUM_DIMS*DATA_WIDTH  per-dimension center; dim d at bits [d*DATA_WIDTH +: DATA_WIDTH].
- s_valid  in  1  point beat valid.
- s_ready  out  1  point beat accepted when s_valid&&s_ready.
- s_data  in  NUM_DIMS*DATA_WIDTH  point coordinates, same packing as center.
- s_last  in  1  final point of run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results valid.
- count_out  out  CNT_W  points accumulated in last run.
- stddev  out  NUM_DIMS*DATA_WIDTH  unsigned per-dimension result, same packing; held until next done.

Function
REQ-005 SHALL implement states IDLE, ACCUM, DIVIDE, SQRT, DONE.
REQ-006 IDLE: s_ready=0; start=1 -> latch center, clear accumulators and count, go ACCUM next cycle; start is ignored in all other states.
REQ-007 ACCUM: s_ready=1; per accepted beat, for each d: diff = s_data[d]-center[d] sign-extended to DATA_WIDTH+1 bits; acc[d] += diff*diff (unsigned, ACC_W bits, cannot overflow); count += 1.
REQ-008 ACCUM exits to DIVIDE on the cycle after the accepting beat has s_last=1 or makes count==MAX_POINTS; s_ready SHALL be 0 from that cycle onward, so beat MAX_POINTS+1 is never accepted.
REQ-009 A cycle with s_valid=0 in ACCUM SHALL leave accumulators and count unchanged.
REQ-010 DIVIDE: per dimension d (processed in order 0..NUM_DIMS-1), sequential restoring division var = floor(acc[d]/count), exactly ACC_W cycles, quotient truncated to 2*DATA_WIDTH bits (never exceeds it).
REQ-011 SQRT: sequential bit-pair integer square root root = floor(sqrt(var)), exactly DATA_WIDTH cycles; root written to stddev[d]; then DIVIDE for d+1, or DONE after last dimension.
REQ-012 Fixed-point: input Q(m.f) yields sum of squares Q(.2f); the root is therefore Q(m.f) with no extra shift.
REQ-013 Latency: if the last beat is accepted in cycle T, done SHALL be high exactly in cycle T+1+NUM_DIMS*(ACC_W+DATA_WIDTH).
REQ-014 DONE: done=1 for one cycle, count_out updated same cycle, return to IDLE next cycle; a start in the DONE cycle is ignored.
REQ-015 stddev and count_out SHALL only change on the done cycle (all dimensions written together from internal result registers).
REQ-016 Single-point run SHALL give stddev=0 for all dimensions; division by zero cannot occur because count>=1 on leaving ACCUM.

Reset
REQ-017 rst=1 at any clock edge, including mid-ACCUM/DIVIDE/SQRT, SHALL force IDLE, s_ready=0, busy=0, done=0, stddev=0, count_out=0, accumulators and count cleared; an aborted run produces no done.
REQ-018 First start accepted on the first cycle with rst=0.

Verification (DATA_WIDTH=16 Q8.8, NUM_DIMS=2, MAX_POINTS=64; ACC_W=39)
REQ-019 center={0,0}; 4 points dim0 = +0x0100,-0x0100,+0x0100,-0x0100, dim1 = 0 -> stddev dim0=0x0100, dim1=0x0000, count_out=4, done exactly 1+2*(39+16)=111 cycles after the last beat.
REQ-020 center dim0=0x0200; points 0x0000,0x0400 -> stddev dim0=0x0200 (negative and positive diffs square equally).
REQ-021 Single point equal to any value, s_last on first beat -> stddev={0,0}, count_out=1.
REQ-022 70 beats with s_last never set -> exactly 64 accepted, s_ready low after 64th, count_out=64, run completes normally.
REQ-023 s_valid gaps (random idle cycles) during ACCUM -> results identical to gap-free run; start pulsed while busy -> ignored, results unchanged.
REQ-024 rst asserted in mid-SQRT -> no done, outputs 0; a following clean run produces correct results.
